// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RISC-V core types: load/store size codes and LSU types.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

  // Load/store size codes follow the funct3 field of the load/store opcodes
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic lsu_illegal(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: lsu_illegal = 1'b0;
      LDST_H, LDST_HU: lsu_illegal = off[0];
      LDST_W:          lsu_illegal = (off != 2'b00);
      default:         lsu_illegal = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu_load_align
// Brief    : Selects the addressed byte/half of a memory word and extends it.
// Revision : 1.0
// ============================================================================
module riscv_lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_offset,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_rd[7:0];
      2'd1:    w_byte = i_rd[15:8];
      2'd2:    w_byte = i_rd[23:16];
      default: w_byte = i_rd[31:24];
    endcase
    w_half = i_offset[1] ? i_rd[31:16] : i_rd[15:0];
  end

  always_comb begin
    case (i_size)
      LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
      LDST_BU: o_data = {24'd0, w_byte};
      LDST_H:  o_data = {{16{w_half[15]}}, w_half};
      LDST_HU: o_data = {16'd0, w_half};
      default: o_data = i_rd;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Brief    : Load-store unit: request FSM, byte enables, store replication,
//            load extension and misalignment rejection.
// Revision : 1.0
// ============================================================================
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  lsu_state_t  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wd;

  logic        w_illegal, w_accept, w_busy;
  logic        w_sel_we;
  logic [2:0]  w_sel_size;
  logic [31:0] w_sel_addr, w_sel_wd;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_load;

  assign w_illegal = lsu_illegal(core_size_i, core_addr_i[1:0]);
  assign w_busy    = (r_state == BUSY);
  assign w_accept  = (r_state == IDLE) && core_req_i && !w_illegal && !rst_i;

  // The accept cycle drives memory from live inputs; BUSY replays the latch
  assign w_sel_we   = w_busy ? r_we   : core_we_i;
  assign w_sel_size = w_busy ? r_size : core_size_i;
  assign w_sel_addr = w_busy ? r_addr : core_addr_i;
  assign w_sel_wd   = w_busy ? r_wd   : core_wd_i;

  always_comb begin
    case (w_sel_size)
      LDST_B, LDST_BU: begin
        w_be = BE_BYTE << w_sel_addr[1:0];
        w_wd = {4{w_sel_wd[7:0]}};
      end
      LDST_H, LDST_HU: begin
        w_be = BE_HALF << w_sel_addr[1:0];
        w_wd = {2{w_sel_wd[15:0]}};
      end
      default: begin
        w_be = BE_WORD;
        w_wd = w_sel_wd;
      end
    endcase
  end

  riscv_lsu_load_align u_load_align (
    .i_rd     (mem_rd_i),
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .o_data   (w_load)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_size <= 3'd0;
      r_addr <= 32'd0;
      r_wd   <= 32'd0;
    end else if (w_accept) begin
      r_we   <= core_we_i;
      r_size <= core_size_i;
      r_addr <= core_addr_i;
      r_wd   <= core_wd_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (core_req_i && !w_illegal) w_next = BUSY;
      BUSY:    if (mem_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    core_rd_o    = 32'd0;
    core_stall_o = 1'b0;
    core_err_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'd0;
    mem_addr_o   = 32'd0;
    mem_wd_o     = 32'd0;
    case (r_state)
      IDLE: begin
        if (core_req_i && !rst_i) begin
          if (w_illegal) begin
            core_err_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
            mem_req_o    = 1'b1;
            mem_we_o     = w_sel_we;
            mem_be_o     = w_be;
            mem_addr_o   = w_sel_addr;
            mem_wd_o     = w_wd;
          end
        end
      end
      BUSY: begin
        core_stall_o = !mem_ready_i;
        mem_req_o    = 1'b1;
        mem_we_o     = w_sel_we;
        mem_be_o     = w_be;
        mem_addr_o   = w_sel_addr;
        mem_wd_o     = w_wd;
        if (mem_ready_i && !r_we) core_rd_o = w_load;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Brief    : Self-checking bench for riscv_lsu with a byte-lane reference model.
// Revision : 1.0
// ============================================================================
module tb_riscv_lsu;

  logic        clk, rst;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd, core_rd;
  logic        core_stall, core_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  riscv_lsu dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .core_err_o   (core_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [103:0] all_out = {core_rd, core_stall, core_err, mem_req, mem_we,
                          mem_be, mem_addr, mem_wd};

  // Reference model: access width in bytes, 0 for an unknown size code
  function automatic int nbytes(input logic [2:0] size);
    case (size)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      3'b010:         nbytes = 4;
      default:        nbytes = 0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    is_legal = (n != 0) && ((addr % n) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [31:0] addr);
    int n;
    n = nbytes(size);
    exp_be = 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] size, input logic [31:0] wd);
    int n;
    n = nbytes(size);
    if (n == 1)      exp_wd = (wd & 32'hFF) * 32'h01010101;
    else if (n == 2) exp_wd = (wd & 32'hFFFF) * 32'h00010001;
    else             exp_wd = wd;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int n;
    logic [31:0] mask, v;
    n    = nbytes(size);
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * n)) - 1);
    v    = (rd >> (8 * (addr % 4))) & mask;
    if ((size == 3'b000 || size == 3'b001) && (((v >> (8 * n - 1)) & 1) == 1))
      v = v | ~mask;
    exp_ld = v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_core();
    core_req  = 1'($urandom);
    core_we   = 1'($urandom);
    core_size = 3'($urandom);
    core_addr = $urandom;
    core_wd   = $urandom;
  endtask

  // One complete access starting in the current (IDLE) cycle
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic [69:0] exp_mem;
    int stalls;
    exp_mem   = {1'b1, we, exp_be(size, addr), addr, exp_wd(size, wd)};
    core_req  = 1'b1;
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
    mem_ready = 1'($urandom);
    mem_rd    = $urandom;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wd} !== exp_mem) begin
      failures++;
      $display("FAIL accept_fields got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr, mem_wd}, exp_mem);
    end
    checks++;
    if ({core_stall, core_err, core_rd} !== {1'b1, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL accept_core got=%h exp=%h", {core_stall, core_err, core_rd}, {1'b1, 1'b0, 32'd0});
    end
    stalls = int'(core_stall);
    step();
    for (int i = 0; i < waits; i++) begin
      scramble_core();
      mem_ready = 1'b0;
      mem_rd    = $urandom;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_stall, core_rd} !== {exp_mem, 1'b1, 32'd0}) begin
        failures++;
        $display("FAIL wait_cycle%0d got=%h exp=%h", i,
                 {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_stall, core_rd}, {exp_mem, 1'b1, 32'd0});
      end
      stalls += int'(core_stall);
      step();
    end
    scramble_core();
    mem_ready = 1'b1;
    mem_rd    = rd;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_stall} !== {exp_mem, 1'b0}) begin
      failures++;
      $display("FAIL ready_fields got=%h exp=%h", {mem_req, mem_we, mem_be, mem_addr, mem_wd, core_stall},
               {exp_mem, 1'b0});
    end
    checks++;
    if (core_rd !== (we ? 32'd0 : exp_ld(size, addr, rd))) begin
      failures++;
      $display("FAIL load_data size=%0d addr=%h got=%h exp=%h", size, addr, core_rd,
               we ? 32'd0 : exp_ld(size, addr, rd));
    end
    step();
    core_req  = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (stalls !== waits + 1) begin
      failures++;
      $display("FAIL stall_cycles got=%0d exp=%0d", stalls, waits + 1);
    end
  endtask

  task automatic check_idle(input string name);
    core_req  = 1'b0;
    mem_ready = 1'b1;
    mem_rd    = $urandom;
    #1;
    checks++;
    if (all_out !== 104'd0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", name, all_out);
    end
    step();
    mem_ready = 1'b0;
  endtask

  task automatic check_illegal(input logic [2:0] size, input logic [31:0] addr);
    core_req  = 1'b1;
    core_we   = 1'($urandom);
    core_size = size;
    core_addr = addr;
    core_wd   = $urandom;
    mem_ready = 1'($urandom);
    #1;
    checks++;
    if ({core_err, core_stall, mem_req, mem_be} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL illegal size=%0d addr=%h got=%b exp=1000000", size, addr,
               {core_err, core_stall, mem_req, mem_be});
    end
    step();
    check_idle("illegal_stays_idle");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scramble_core();
    core_req  = 1'b1;
    core_size = 3'b010;
    core_addr = 32'h10;
    mem_ready = 1'b1;
    mem_rd    = $urandom;
    #2;
    checks++;
    if (all_out !== 104'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    step();
    step();
    #2 rst = 1'b0;
    core_req  = 1'b0;
    mem_ready = 1'b0;
    step();
    check_idle("post_reset_idle");
  endtask

  task automatic test_store();
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, $urandom, 3);
    check_idle("sw_done_idle");
    do_access(1'b1, 3'b000, 32'h103, 32'h000000A5, $urandom, 0);
    check_idle("sb_done_idle");
    do_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, $urandom, 1);
    check_idle("sh_done_idle");
  endtask

  task automatic test_load_ext();
    do_access(1'b0, 3'b000, 32'h2, 32'h0, 32'h0080FF00, 0);
    do_access(1'b0, 3'b100, 32'h2, 32'h0, 32'h0080FF00, 1);
    do_access(1'b0, 3'b001, 32'h2, 32'h0, 32'h0080FF00, 0);
    do_access(1'b0, 3'b101, 32'h0, 32'h0, 32'h0080FF00, 2);
    do_access(1'b0, 3'b001, 32'h0, 32'h0, 32'h0080FF00, 0);
    do_access(1'b0, 3'b010, 32'h4, 32'h0, 32'h89ABCDEF, 0);
    check_idle("load_done_idle");
  endtask

  task automatic test_illegal();
    check_illegal(3'b010, 32'h101);
    check_illegal(3'b001, 32'h3);
    check_illegal(3'b011, 32'h0);
    check_illegal(3'b101, 32'h7);
    check_illegal(3'b111, 32'h8);
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0);
    do_access(1'b1, 3'b010, 32'h304, 32'h0BADC0DE, $urandom, 0);
    do_access(1'b0, 3'b000, 32'h305, 32'h0, 32'h00008000, 0);
    check_idle("b2b_done_idle");
  endtask

  task automatic test_reset_mid_busy();
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_size = 3'b010;
    core_addr = 32'h40;
    core_wd   = $urandom;
    mem_ready = 1'b0;
    step();
    checks++;
    if ({mem_req, core_stall} !== 2'b11) begin
      failures++;
      $display("FAIL busy_before_reset got=%b exp=11", {mem_req, core_stall});
    end
    core_req = 1'b1;
    rst      = 1'b1;
    #1;
    checks++;
    if (all_out !== 104'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h exp=0", all_out);
    end
    step();
    #3 rst = 1'b0;
    core_req = 1'b0;
    step();
    check_idle("after_reset_idle");
    do_access(1'b1, 3'b001, 32'h42, 32'h00005A5A, $urandom, 1);
    check_idle("after_reset_access_idle");
  endtask

  task automatic test_random();
    logic [2:0]  size;
    logic [31:0] addr;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: size = 3'b000;
        1: size = 3'b001;
        2: size = 3'b010;
        3: size = 3'b100;
        4: size = 3'b101;
        5: size = 3'b011;
        default: size = 3'($urandom);
      endcase
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & 32'hFFFF_FFFC | 32'(2 * $urandom_range(0, 1));
      if (is_legal(size, addr))
        do_access(1'($urandom), size, addr, $urandom, $urandom, $urandom_range(0, 3));
      else
        check_illegal(size, addr);
    end
    check_idle("random_done_idle");
  endtask

  initial begin
    rst       = 1'b1;
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_size = 3'd0;
    core_addr = 32'd0;
    core_wd   = 32'd0;
    mem_rd    = 32'd0;
    mem_ready = 1'b0;
    test_reset();
    test_store();
    test_load_ext();
    test_illegal();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
